// File: rtl/fwd_hazard_unit_if.sv
// ID-side bundle for the forwarding / hazard unit.
// Core drives ID metadata; the unit returns stall and mux selects.
interface fwd_hazard_unit_if #(
  parameter int REG_ADDR_W = 5
);

  logic                  id_valid_i;
  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic                  id_use_rs1_i;
  logic                  id_use_rs2_i;
  logic [REG_ADDR_W-1:0] id_rd_i;
  logic                  id_regwrite_i;
  logic                  id_memread_i;
  logic                  flush_i;
  logic                  stall_o;
  logic [1:0]            fwd_a_sel_o;
  logic [1:0]            fwd_b_sel_o;

  modport master (
    output id_valid_i,
    output id_rs1_i,
    output id_rs2_i,
    output id_use_rs1_i,
    output id_use_rs2_i,
    output id_rd_i,
    output id_regwrite_i,
    output id_memread_i,
    output flush_i,
    input  stall_o,
    input  fwd_a_sel_o,
    input  fwd_b_sel_o
  );

  modport slave (
    input  id_valid_i,
    input  id_rs1_i,
    input  id_rs2_i,
    input  id_use_rs1_i,
    input  id_use_rs2_i,
    input  id_rd_i,
    input  id_regwrite_i,
    input  id_memread_i,
    input  flush_i,
    output stall_o,
    output fwd_a_sel_o,
    output fwd_b_sel_o
  );

endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall for the 5-stage core.
// Optional stall counter port: define HAZARD_STALL_CNT_EN.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fwd_hazard_unit_if.slave bus
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  typedef logic [REG_ADDR_W-1:0] reg_t;

  logic ex_valid_q, ex_valid_d;
  reg_t ex_rd_q,    ex_rd_d;
  reg_t ex_rs1_q,   ex_rs1_d;
  reg_t ex_rs2_q,   ex_rs2_d;
  logic ex_wr_q,    ex_wr_d;
  logic ex_ld_q,    ex_ld_d;

  reg_t mem_rd_q;
  logic mem_wr_q;
  reg_t wb_rd_q;
  logic wb_wr_q;

  logic hit_rs1;
  logic hit_rs2;
  logic stall;
  logic bubble;

  // Load in EX whose rd is read by the ID instruction.
  always_comb begin
    hit_rs1 = bus.id_use_rs1_i && (bus.id_rs1_i == ex_rd_q);
    hit_rs2 = bus.id_use_rs2_i && (bus.id_rs2_i == ex_rd_q);
    stall   = bus.id_valid_i && !bus.flush_i
           && ex_valid_q && ex_ld_q
           && (ex_rd_q != '0)
           && (hit_rs1 || hit_rs2);
  end

  assign bus.stall_o = stall;

  // Next EX contents: ID instruction or a bubble.
  always_comb begin
    bubble     = stall || bus.flush_i || !bus.id_valid_i;
    ex_valid_d = 1'b0;
    ex_rd_d    = '0;
    ex_rs1_d   = '0;
    ex_rs2_d   = '0;
    ex_wr_d    = 1'b0;
    ex_ld_d    = 1'b0;
    if (!bubble) begin
      ex_valid_d = 1'b1;
      ex_rd_d    = bus.id_rd_i;
      ex_rs1_d   = bus.id_rs1_i;
      ex_rs2_d   = bus.id_rs2_i;
      ex_wr_d    = bus.id_regwrite_i;
      ex_ld_d    = bus.id_memread_i;
    end
  end

  // Advance EX -> MEM -> WB metadata every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_wr_q    <= 1'b0;
      ex_ld_q    <= 1'b0;
      mem_rd_q   <= '0;
      mem_wr_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_wr_q    <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_wr_q    <= ex_wr_d;
      ex_ld_q    <= ex_ld_d;
      mem_rd_q   <= ex_rd_q;
      mem_wr_q   <= ex_wr_q;
      wb_rd_q    <= mem_rd_q;
      wb_wr_q    <= mem_wr_q;
    end
  end

  function automatic logic [1:0] fwd_sel(input reg_t rs);
    logic mem_hit;
    logic wb_hit;
    mem_hit = mem_wr_q && (mem_rd_q != '0) && (mem_rd_q == rs);
    wb_hit  = wb_wr_q && (wb_rd_q != '0) && (wb_rd_q == rs);
    if (mem_hit)
      return SEL_MEM;
    else if (wb_hit)
      return SEL_WB;
    else
      return SEL_RF;
  endfunction

  // Selects from registered state only; MEM (newer) wins over WB.
  always_comb begin
    bus.fwd_a_sel_o = fwd_sel(ex_rs1_q);
    bus.fwd_b_sel_o = fwd_sel(ex_rs2_q);
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign stall_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit.
// Reference model tracks instructions in flight per stage.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fwd_hazard_unit_if #(.REG_ADDR_W(5)) bus ();

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] cnt_dut;
`endif

  fwd_hazard_unit #(
    .REG_ADDR_W(5),
    .CNT_W(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus.slave)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt_o(cnt_dut)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ins_t;

  typedef struct packed {
    logic        stall;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [31:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  ins_t pipe[3];
  logic [31:0] cnt_m;
  bit known = 0;

  function automatic ins_t mk(input logic [4:0] rd, input bit wr,
                              input bit ld, input logic [4:0] rs1,
                              input bit u1, input logic [4:0] rs2,
                              input bit u2);
    ins_t i;
    i.valid = 1'b1;
    i.rd = rd; i.wr = wr; i.ld = ld;
    i.rs1 = rs1; i.use1 = u1;
    i.rs2 = rs2; i.use2 = u2;
    return i;
  endfunction

  // Newest older writer of r wins; x0 never forwarded.
  function automatic logic [1:0] fwd_for(input logic [4:0] r);
    for (int age = 1; age <= 2; age++) begin
      if (pipe[age].valid && pipe[age].wr &&
          pipe[age].rd != 0 && pipe[age].rd == r)
        return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic step(input ins_t ins, input bit fl, input bit rs,
                      output bit st);
    exp_t e;
    bit reads_ld;
    bus.id_valid_i    = ins.valid;
    bus.id_rs1_i      = ins.rs1;
    bus.id_rs2_i      = ins.rs2;
    bus.id_use_rs1_i  = ins.use1;
    bus.id_use_rs2_i  = ins.use2;
    bus.id_rd_i       = ins.rd;
    bus.id_regwrite_i = ins.wr;
    bus.id_memread_i  = ins.ld;
    bus.flush_i       = fl;
    rst               = rs;
    st = 0;
    if (known) begin
      reads_ld = (ins.use1 && ins.rs1 == pipe[0].rd) ||
                 (ins.use2 && ins.rs2 == pipe[0].rd);
      e.stall = ins.valid && !fl && pipe[0].valid && pipe[0].ld &&
                pipe[0].rd != 0 && reads_ld;
      e.a = fwd_for(pipe[0].rs1);
      e.b = fwd_for(pipe[0].rs2);
      e.cnt = cnt_m;
      sbq.push_back(e);
      st = e.stall;
    end
    if (rs) begin
      for (int k = 0; k < 3; k++) pipe[k] = '0;
      cnt_m = 0;
      known = 1;
    end else if (known) begin
      if (st && cnt_m != 32'hffff_ffff) cnt_m = cnt_m + 1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (st || fl || !ins.valid) ? ins_t'('0) : ins;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h exp %0h", nm, cyc, got, want);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("stall", 32'(bus.stall_o), 32'(e.stall));
      chk("fwd_a", 32'(bus.fwd_a_sel_o), 32'(e.a));
      chk("fwd_b", 32'(bus.fwd_b_sel_o), 32'(e.b));
`ifdef HAZARD_STALL_CNT_EN
      chk("stall_cnt", cnt_dut, e.cnt);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    ins_t nop, c, r;
    bit st;
    nop = '0;
    bus.id_valid_i = 0; bus.id_rs1_i = 0; bus.id_rs2_i = 0;
    bus.id_use_rs1_i = 0; bus.id_use_rs2_i = 0; bus.id_rd_i = 0;
    bus.id_regwrite_i = 0; bus.id_memread_i = 0; bus.flush_i = 0;
    @(posedge clk); #1;

    step(nop, 0, 1, st);
    step(nop, 0, 1, st);
    step(nop, 0, 0, st);

    // EX/MEM forward
    step(mk(5, 1, 0, 1, 1, 2, 1), 0, 0, st);
    step(mk(9, 1, 0, 5, 1, 3, 1), 0, 0, st);
    step(nop, 0, 0, st);
    step(nop, 0, 0, st);

    // MEM/WB forward
    step(mk(6, 1, 0, 1, 1, 1, 1), 0, 0, st);
    step(mk(10, 1, 0, 2, 1, 3, 1), 0, 0, st);
    step(mk(11, 1, 0, 1, 1, 6, 1), 0, 0, st);
    step(nop, 0, 0, st);
    step(nop, 0, 0, st);

    // MEM beats WB
    step(mk(6, 1, 0, 1, 1, 1, 1), 0, 0, st);
    step(mk(6, 1, 0, 2, 1, 2, 1), 0, 0, st);
    step(mk(12, 1, 0, 6, 1, 6, 1), 0, 0, st);
    step(nop, 0, 0, st);
    step(nop, 0, 0, st);

    // Load-use
    step(mk(7, 1, 1, 1, 1, 0, 0), 0, 0, st);
    c = mk(13, 1, 0, 7, 1, 0, 0);
    step(c, 0, 0, st);
    step(c, 0, 0, st);
    step(nop, 0, 0, st);
    step(nop, 0, 0, st);

    // x0 writer
    step(mk(0, 1, 0, 1, 1, 0, 0), 0, 0, st);
    step(mk(14, 1, 0, 0, 1, 0, 1), 0, 0, st);
    step(nop, 0, 0, st);
    step(nop, 0, 0, st);

    // Flush beats load-use stall
    step(mk(8, 1, 1, 1, 1, 0, 0), 0, 0, st);
    step(mk(8, 1, 0, 8, 1, 8, 1), 1, 0, st);
    step(nop, 0, 0, st);
    step(nop, 0, 0, st);

    // Reset during a stall
    step(mk(7, 1, 1, 1, 1, 0, 0), 0, 0, st);
    c = mk(15, 1, 0, 7, 1, 0, 0);
    step(c, 0, 0, st);
    step(c, 0, 1, st);
    step(nop, 0, 0, st);
    step(nop, 0, 0, st);

    // Random traffic; a stalled ID instruction is re-presented
    r = nop;
    st = 0;
    for (int n = 0; n < 600; n++) begin
      if (!st) begin
        r.valid = ($urandom_range(9) != 0);
        r.rd    = 5'($urandom_range(7));
        r.rs1   = 5'($urandom_range(7));
        r.rs2   = 5'($urandom_range(7));
        r.use1  = 1'($urandom_range(1));
        r.use2  = 1'($urandom_range(1));
        r.wr    = ($urandom_range(3) != 0);
        r.ld    = ($urandom_range(2) == 0);
      end
      step(r, ($urandom_range(9) == 0), ($urandom_range(49) == 0), st);
    end
    step(nop, 0, 0, st);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d exp 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
